// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that stores its entries in an external single-port SRAM,
// using a two-cycle write (setup, strobe) and a two-cycle read (setup, capture).
// Optional protocol-error flag: define SRAM_FIFO_CTRL_ERR_EN to build the sticky Err register.
module sram_fifo_ctrl #(
  parameter int AW = 2,
  parameter int DW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Push,
  input  logic [DW-1:0] Din,
  input  logic          Pop,
  output logic [DW-1:0] Dout,
  output logic          Valid,
  output logic          Busy,
  output logic          Full,
  output logic          Empty,
  output logic          Err,
  output logic [AW-1:0] SramAddr,
  output logic [DW-1:0] SramDin,
  output logic          SramRW,
  input  logic [DW-1:0] SramDout
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD_SETUP,
    RD_CAPTURE
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          idle;
  logic          push_acc;
  logic          pop_acc;
  logic          push_ok;
  logic          pop_ok;

  assign idle     = (state == IDLE);
  assign push_acc = Push && !Full;
  assign pop_acc  = Pop && !Empty;
  assign push_ok  = idle && push_acc;
  assign pop_ok   = idle && pop_acc && !push_acc;

  assign Busy  = !idle;
  assign Full  = (count == DEPTH);
  assign Empty = (count == '0);

  // SRAM pins are registered; each transition loads the values the next state drives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      Dout     <= '0;
      Valid    <= 1'b0;
      SramRW   <= 1'b0;
      SramAddr <= '0;
      SramDin  <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (push_ok) begin
            state    <= WR_SETUP;
            SramAddr <= wptr;
            SramDin  <= Din;
          end else if (pop_ok) begin
            state    <= RD_SETUP;
            SramAddr <= rptr;
          end
        end
        WR_SETUP: begin
          state  <= WR_STROBE;
          SramRW <= 1'b1;
        end
        WR_STROBE: begin
          state    <= IDLE;
          SramRW   <= 1'b0;
          SramAddr <= rptr;
          SramDin  <= '0;
          wptr     <= wptr + 1'b1;
          count    <= count + 1'b1;
        end
        RD_SETUP: begin
          state <= RD_CAPTURE;
          Dout  <= SramDout;
          Valid <= 1'b1;
        end
        RD_CAPTURE: begin
          state    <= IDLE;
          rptr     <= rptr + 1'b1;
          SramAddr <= rptr + 1'b1;
          count    <= count - 1'b1;
        end
        default: begin
          state    <= IDLE;
          SramRW   <= 1'b0;
          SramAddr <= rptr;
          SramDin  <= '0;
        end
      endcase
    end
  end

`ifdef SRAM_FIFO_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (idle && ((Push && Full && !pop_acc) || (Pop && Empty && !push_acc))) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter AW, default 2, SRAM address width; FIFO depth = 2**AW.
REQ-002 Parameter DW, default 4, data width.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 Push  input  1  write request; accepted only per REQ-013.
REQ-006 Din  input  DW  write data, sampled on the cycle Push is accepted.
REQ-007 Pop  input  1  read request; accepted only per REQ-013.
REQ-008 Dout  output  DW  read data, registered, held until the next read completes.
REQ-009 Valid  output  1  one-cycle pulse, Dout updated this cycle.
REQ-010 Busy, Full, Empty  output  1 each  controller not in IDLE; count==2**AW; count==0.
REQ-011 Err  output  1  sticky protocol-error flag, per REQ-024.
REQ-012 SramAddr (AW), SramDin (DW), SramRW (1) outputs; SramDout (DW) input; drive the downstream 4x4 SRAM address, data, write-strobe and read-data pins.

Function
REQ-013 Acceptance occurs only in IDLE: Push accepted when Push && !Full; else Pop accepted when Pop && !Empty; if both are acceptable, Push wins and Pop must be re-asserted.
REQ-014 FSM states: IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_CAPTURE; no other encodings reachable.
REQ-015 Write path: IDLE -(Push accepted)-> WR_SETUP -> WR_STROBE -> IDLE.
REQ-016 WR_SETUP: SramAddr=wptr, SramDin=latched Din, SramRW=0; WR_STROBE: same address/data, SramRW=1.
REQ-017 On WR_STROBE exit: wptr+=1 modulo 2**AW, count+=1.
REQ-018 SramAddr and SramDin stable across both write-state cycles, so the SRAM's rising-edge RW write sees settled data.
REQ-019 Read path: IDLE -(Pop accepted)-> RD_SETUP -> RD_CAPTURE -> IDLE; SramAddr=rptr in both states, SramRW=0.
REQ-020 RD_CAPTURE: Dout<=SramDout, Valid=1 for exactly that cycle, rptr+=1 modulo 2**AW, count-=1.
REQ-021 Latency: accept cycle N -> SramRW high cycle N+2 (write); Valid high cycle N+2 (read); next acceptance earliest cycle N+3.
REQ-022 Pointer wrap from 2**AW-1 to 0 silent; count width AW+1, never exceeds 2**AW nor drops below 0.
REQ-023 Busy=1 in every non-IDLE state; Push/Pop ignored while Busy.
REQ-024 Err set in IDLE on Push && Full with no Pop acceptable, or Pop && Empty with no Push acceptable; cleared only by RST.
REQ-025 In IDLE SramRW=0, SramAddr=rptr, SramDin=0.

Reset
REQ-026 RST high at a rising edge forces: state IDLE, wptr=rptr=0, count=0, Dout=0, Valid=0, Err=0, SramRW=0, SramAddr=0, SramDin=0.
REQ-027 Reset mid-operation aborts the access: no pointer/count update, no Valid, SramRW low the next cycle.
REQ-028 Empty=1, Full=0, Busy=0 during and after reset.

Configuration
REQ-029 Macro SRAM_FIFO_CTRL_ERR_EN: defined -> Err logic per REQ-024; undefined -> Err tied 0, no Err register, all other behaviour identical.

Verification
REQ-030 Reset, Push Din=4'hA -> cycle+1 SramAddr=0, SramDin=A, SramRW=0; cycle+2 SramRW=1; cycle+3 Busy=0, Empty=0.
REQ-031 Push 1,2,3,4 -> Full=1; fifth Push ignored, count stays 4, Err=1 (macro on) / 0 (macro off).
REQ-032 After REQ-031, Pop x4 -> Valid pulses with Dout 1,2,3,4 in order, Empty=1 after last; SramAddr 0,1,2,3.
REQ-033 Push x3, Pop x3, Push x3 -> wptr wraps 3->0->1->2, pops return data in push order, count never >4.
REQ-034 Push and Pop asserted together, count=1 -> Push serviced first; with count=4 -> Pop serviced.
REQ-035 RST asserted in WR_STROBE -> next cycle SramRW=0, count=0, Empty=1, subsequent Pop sets Err (macro on), no Valid.
